// File: rtl/bool_op_pkg.sv
// Shared definitions for the boolean-op arbiter: op codes and FSM state encoding.
package bool_op_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND    = 3'd0;
  localparam logic [OP_W-1:0] OP_OR     = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_PASS_B = 3'd6;
  localparam logic [OP_W-1:0] OP_NOT_A  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/bool_alu.sv
// Combinational bitwise boolean unit; every result bit depends only on its own operand bits.
module bool_alu
  import bool_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic y_bit;

      always_comb begin
        y_bit = 1'b0;
        case (op)
          OP_AND:    y_bit = a[gi] & b[gi];
          OP_OR:     y_bit = a[gi] | b[gi];
          OP_XOR:    y_bit = a[gi] ^ b[gi];
          OP_NAND:   y_bit = ~(a[gi] & b[gi]);
          OP_NOR:    y_bit = ~(a[gi] | b[gi]);
          OP_XNOR:   y_bit = ~(a[gi] ^ b[gi]);
          OP_PASS_B: y_bit = (a[gi] & b[gi]) | (~a[gi] & b[gi]);
          OP_NOT_A:  y_bit = ~a[gi];
          default:   y_bit = 1'b0;
        endcase
      end

      assign y[gi] = y_bit;
    end
  endgenerate

endmodule

// File: rtl/bool_op_arbiter.sv
// Round-robin arbiter sharing one bool_alu among N_REQ requesters; one transaction
// walks IDLE -> EXEC -> RESP and the result is returned tagged with the owner id.
module bool_op_arbiter
  import bool_op_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ*OP_W-1:0]    req_op,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         txn_count
);

  localparam int ID_W = $clog2(N_REQ);

  state_t state_reg, state_next;

  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  grant_sel;
  logic             any_valid;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [OP_W-1:0]  op_reg;
  logic [ID_W-1:0]  id_reg;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] resp_data_reg;
  logic [ID_W-1:0]  resp_id_reg;
  logic             resp_valid_reg;
  logic [CNT_W-1:0] txn_count_reg;

  logic [WIDTH-1:0] a_arr  [N_REQ];
  logic [WIDTH-1:0] b_arr  [N_REQ];
  logic [OP_W-1:0]  op_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
      assign op_arr[gi] = req_op[gi*OP_W +: OP_W];
    end
  endgenerate

  assign any_valid = |req_valid;

  // Search starts just after the last winner, so the previous grantee has lowest priority.
  always_comb begin
    logic [ID_W-1:0] cand;
    logic            found;
    grant_sel = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(ptr_reg) + i) % N_REQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_sel = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = any_valid ? EXEC : IDLE;
      EXEC:    state_next = RESP;
      RESP:    state_next = (resp_valid_reg && resp_ready) ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    case (state_reg)
      IDLE: if (any_valid) req_ready[grant_sel] = 1'b1;
      EXEC: busy = 1'b1;
      RESP: busy = 1'b1;
      default: ;
    endcase
  end

  bool_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (a_reg),
    .b  (b_reg),
    .op (op_reg),
    .y  (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg        <= ID_W'(N_REQ - 1);
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      id_reg         <= '0;
      resp_data_reg  <= '0;
      resp_id_reg    <= '0;
      resp_valid_reg <= 1'b0;
      txn_count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            a_reg   <= a_arr[grant_sel];
            b_reg   <= b_arr[grant_sel];
            op_reg  <= op_arr[grant_sel];
            id_reg  <= grant_sel;
            ptr_reg <= grant_sel;
          end
        end
        EXEC: begin
          resp_data_reg  <= alu_y;
          resp_id_reg    <= id_reg;
          resp_valid_reg <= 1'b1;
        end
        RESP: begin
          if (resp_valid_reg && resp_ready) begin
            resp_valid_reg <= 1'b0;
            if (txn_count_reg != {CNT_W{1'b1}}) txn_count_reg <= txn_count_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign resp_id    = resp_id_reg;
  assign txn_count  = txn_count_reg;

endmodule

// File: tb/tb_bool_op_arbiter.sv
// Directed bench for bool_op_arbiter: grants, ALU ops, backpressure, reset and counter saturation.
module tb_bool_op_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [11:0] req_op = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;
  logic        busy;
  logic [15:0] txn_count;

  logic [3:0]  sat_req_ready;
  logic        sat_resp_valid;
  logic [7:0]  sat_resp_data;
  logic [1:0]  sat_resp_id;
  logic        sat_busy;
  logic [2:0]  sat_txn_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bool_op_arbiter #(.N_REQ(4), .WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
    .busy(busy), .txn_count(txn_count)
  );

  // Narrow counter copy so saturation is reachable in a few transactions.
  bool_op_arbiter #(.N_REQ(4), .WIDTH(8), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(sat_req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(sat_resp_valid),
    .resp_ready(resp_ready), .resp_data(sat_resp_data), .resp_id(sat_resp_id),
    .busy(sat_busy), .txn_count(sat_txn_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    req_a[idx*8 +: 8]  = a;
    req_b[idx*8 +: 8]  = b;
    req_op[idx*3 +: 3] = op;
  endtask

  // One transaction from a single requester, starting and ending in IDLE.
  task automatic run_txn(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] exp_data);
    set_req(idx, a, b, op);
    req_valid = 4'(1 << idx);
    #1;
    chk("txn_ready", 32'(req_ready), 32'(1 << idx));
    tick();
    req_valid = '0;
    chk("txn_busy", 32'(busy), 32'd1);
    chk("txn_early_valid", 32'(resp_valid), 32'd0);
    tick();
    chk("txn_valid", 32'(resp_valid), 32'd1);
    chk("txn_data", 32'(resp_data), 32'(exp_data));
    chk("txn_id", 32'(resp_id), 32'(idx));
    $display("txn id=%0d op=%0d a=%02h b=%02h data=%02h", resp_id, op, a, b, resp_data);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("txn_done", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [1:0] order [5];
    logic [7:0] xor_exp [4];
    logic [7:0] sweep_exp [8];
    order     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    xor_exp   = '{8'h0E, 8'h0D, 8'h0B, 8'h07};
    sweep_exp = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'hAA, 8'h33};

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data", 32'(resp_data), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(txn_count), 32'd0);

    // Basic AND from requester 0
    run_txn(0, 8'hF0, 8'h3C, 3'd0, 8'h30);
    chk("t1_count", 32'(txn_count), 32'd1);

    // All four continuously valid: round robin from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 8'h0F, 8'(1 << i), 3'd2);
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << order[k]));
      chk("rr_idle_valid", 32'(resp_valid), 32'd0);
      tick();
      chk("rr_ready_pulse", 32'(req_ready), 32'd0);
      tick();
      chk("rr_valid", 32'(resp_valid), 32'd1);
      chk("rr_id", 32'(resp_id), 32'(order[k]));
      chk("rr_data", 32'(resp_data), 32'(xor_exp[order[k]]));
      $display("txn id=%0d data=%02h", resp_id, resp_data);
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b0;
    chk("rr_count", 32'(txn_count), 32'd5);

    // Op coverage on requester 1
    run_txn(1, 8'hAA, 8'h55, 3'd6, 8'h55);
    run_txn(1, 8'hAA, 8'hFF, 3'd7, 8'h55);
    for (int o = 0; o < 8; o++) run_txn(1, 8'hCC, 8'hAA, 3'(o), sweep_exp[o]);
    chk("ops_count", 32'(txn_count), 32'd15);

    // Backpressure: result held, other requests wait
    set_req(2, 8'hF0, 8'h0F, 3'd1);
    set_req(3, 8'h12, 8'h34, 3'd0);
    req_valid = 4'b0100;
    #1;
    chk("bp_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1011;
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", 32'(resp_data), 32'hFF);
      chk("bp_id", 32'(resp_id), 32'd2);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    $display("txn id=%0d data=%02h (after stall)", resp_id, resp_data);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    tick();
    chk("bp3_valid", 32'(resp_valid), 32'd1);
    chk("bp3_id", 32'(resp_id), 32'd3);
    chk("bp3_data", 32'(resp_data), 32'h10);
    $display("txn id=%0d data=%02h", resp_id, resp_data);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_count", 32'(txn_count), 32'd17);

    // Reset while in EXEC drops the transaction
    set_req(0, 8'hFF, 8'hFF, 3'd0);
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    chk("mid_busy", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(resp_data), 32'd0);
    chk("mid_rst_count", 32'(txn_count), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_no_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("mid_no_resp2", 32'(resp_valid), 32'd0);
    set_req(2, 8'h0F, 8'hF0, 3'd5);
    set_req(0, 8'h3C, 8'h0F, 3'd1);
    req_valid = 4'b0101;
    #1;
    chk("mid_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("mid_valid", 32'(resp_valid), 32'd1);
    chk("mid_id", 32'(resp_id), 32'd0);
    chk("mid_data", 32'(resp_data), 32'h3F);
    $display("txn id=%0d data=%02h", resp_id, resp_data);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("mid_count", 32'(txn_count), 32'd1);

    // Counter saturation on the narrow-counter instance
    for (int n = 0; n < 6; n++) run_txn(0, 8'h0F, 8'hF0, 3'd2, 8'hFF);
    chk("sat_at_max", 32'(sat_txn_count), 32'd7);
    chk("wide_at_7", 32'(txn_count), 32'd7);
    run_txn(0, 8'h0F, 8'hF0, 3'd2, 8'hFF);
    chk("sat_stuck", 32'(sat_txn_count), 32'd7);
    chk("wide_at_8", 32'(txn_count), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
